jump_trajectory: RTL and testbench



---
 rtl/jump_trajectory_if.sv | 39 +++
 rtl/jump_trajectory.sv | 183 ++++++++++++++++++
 tb/tb_jump_trajectory.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/jump_trajectory_if.sv
// ---------------------------------------------------------------------------
// jump_trajectory_if
//   Bundle between the game FSM and the jump physics stage.
//   master : game FSM side (drives the jump request and initial velocity)
//   slave  : jump_trajectory side (returns height, distance, done, busy)
// Signals:
//   i_jump_en     1   level jump request, held high for the whole jump
//   i_v_init      11  initial vertical velocity (0..127 meaningful)
//   o_jump_done   1   landing flag (level)
//   o_jump_dist   11  cumulative horizontal distance, pixels
//   o_jump_height 9   current height above the block, pixels
//   o_busy        1   high while airborne
// ---------------------------------------------------------------------------
interface jump_trajectory_if;
   logic        i_jump_en;
   logic [10:0] i_v_init;
   logic        o_jump_done;
   logic [10:0] o_jump_dist;
   logic [8:0]  o_jump_height;
   logic        o_busy;

   modport master (
      output i_jump_en,
      output i_v_init,
      input  o_jump_done,
      input  o_jump_dist,
      input  o_jump_height,
      input  o_busy
   );

   modport slave (
      input  i_jump_en,
      input  i_v_init,
      output o_jump_done,
      output o_jump_dist,
      output o_jump_height,
      output o_busy
   );
endinterface

// File: rtl/jump_trajectory.sv
// ---------------------------------------------------------------------------
// jump_trajectory
//   Physics stage downstream of the game FSM. On a jump request it integrates
//   a discrete parabola: vertical velocity drops by GRAVITY each physics tick,
//   height accumulates velocity, and distance advances by VX per tick. Landing
//   is reported with a level done flag that is held until the request drops.
// Ports:
//   clk_machine  in   system clock
//   rst_machine  in   asynchronous active-high reset
//   bus          slave modport of jump_trajectory_if (request in, results out)
// Parameters:
//   TICK_DIV  clk_machine cycles per physics tick
//   GRAVITY   velocity decrement per tick
//   VX        distance increment per tick
//   HSHIFT    right shift from height accumulator to pixel height
// ---------------------------------------------------------------------------
module jump_trajectory #(
   parameter int TICK_DIV = 100000,
   parameter int GRAVITY  = 1,
   parameter int VX       = 1,
   parameter int HSHIFT   = 5
) (
   input  logic              clk_machine,
   input  logic              rst_machine,
   jump_trajectory_if.slave  bus
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [11:0]      DIST_MAX  = 12'd2047;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FLY  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_r,    state_nx_s;
   logic [CNT_W-1:0]   tick_cnt_r, tick_cnt_nx_s;
   logic signed [11:0] vy_r,       vy_nx_s;
   logic signed [14:0] h_acc_r,    h_acc_nx_s;
   logic [10:0]        dist_r,     dist_nx_s;
   logic [8:0]         height_r,   height_nx_s;
   logic               done_r,     done_nx_s;
   logic               busy_r,     busy_nx_s;

   logic               tick_hit_s;
   logic signed [14:0] h_sum_s;
   logic signed [14:0] h_shift_s;
   logic               land_s;
   logic [11:0]        dist_inc_s;
   logic [10:0]        dist_sat_s;
   logic [6:0]         v_sat_s;

   // Datapath helpers: tick detect, height integration, landing test, saturations
   always_comb begin
      tick_hit_s = (tick_cnt_r == TICK_LAST);
      h_sum_s    = h_acc_r + {{3{vy_r[11]}}, vy_r};
      h_shift_s  = h_sum_s >>> HSHIFT;
      // Land only on the way down (vy <= 0) once the next height reaches the block
      land_s     = (vy_r <= 12'sd0) && (h_sum_s <= 15'sd0);
      dist_inc_s = {1'b0, dist_r} + 12'(VX);
      if (dist_inc_s > DIST_MAX) begin
         dist_sat_s = 11'h7FF;
      end else begin
         dist_sat_s = dist_inc_s[10:0];
      end
      if (bus.i_v_init > 11'd127) begin
         v_sat_s = 7'd127;
      end else begin
         v_sat_s = bus.i_v_init[6:0];
      end
   end

   // Next-state and next-register logic of the jump FSM
   always_comb begin
      state_nx_s    = state_r;
      tick_cnt_nx_s = tick_cnt_r;
      vy_nx_s       = vy_r;
      h_acc_nx_s    = h_acc_r;
      dist_nx_s     = dist_r;
      height_nx_s   = height_r;
      done_nx_s     = done_r;
      busy_nx_s     = busy_r;

      case (state_r)
         IDLE: begin
            height_nx_s = 9'd0;
            done_nx_s   = 1'b0;
            if (bus.i_jump_en) begin
               state_nx_s    = FLY;
               vy_nx_s       = {5'd0, v_sat_s};
               h_acc_nx_s    = 15'sd0;
               dist_nx_s     = 11'd0;
               tick_cnt_nx_s = '0;
               busy_nx_s     = 1'b1;
            end else begin
               busy_nx_s     = 1'b0;
            end
         end

         FLY: begin
            if (!bus.i_jump_en) begin
               // Abort: drop height, keep distance, never report done
               state_nx_s    = IDLE;
               tick_cnt_nx_s = '0;
               vy_nx_s       = 12'sd0;
               h_acc_nx_s    = 15'sd0;
               height_nx_s   = 9'd0;
               busy_nx_s     = 1'b0;
               done_nx_s     = 1'b0;
            end else if (tick_hit_s) begin
               tick_cnt_nx_s = '0;
               dist_nx_s     = dist_sat_s;
               if (land_s) begin
                  state_nx_s  = DONE;
                  h_acc_nx_s  = 15'sd0;
                  height_nx_s = 9'd0;
                  done_nx_s   = 1'b1;
                  busy_nx_s   = 1'b0;
               end else begin
                  h_acc_nx_s  = h_sum_s;
                  height_nx_s = h_shift_s[8:0];
                  vy_nx_s     = vy_r - $signed(12'(GRAVITY));
               end
            end else begin
               tick_cnt_nx_s = tick_cnt_r + 1'b1;
            end
         end

         DONE: begin
            height_nx_s = 9'd0;
            busy_nx_s   = 1'b0;
            if (!bus.i_jump_en) begin
               state_nx_s = IDLE;
               done_nx_s  = 1'b0;
            end else begin
               done_nx_s  = 1'b1;
            end
         end

         default: begin
            state_nx_s    = IDLE;
            tick_cnt_nx_s = '0;
            vy_nx_s       = 12'sd0;
            h_acc_nx_s    = 15'sd0;
            dist_nx_s     = 11'd0;
            height_nx_s   = 9'd0;
            done_nx_s     = 1'b0;
            busy_nx_s     = 1'b0;
         end
      endcase
   end

   // State and datapath registers with asynchronous reset
   always_ff @(posedge clk_machine or posedge rst_machine) begin
      if (rst_machine) begin
         state_r    <= IDLE;
         tick_cnt_r <= '0;
         vy_r       <= 12'sd0;
         h_acc_r    <= 15'sd0;
         dist_r     <= 11'd0;
         height_r   <= 9'd0;
         done_r     <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         tick_cnt_r <= tick_cnt_nx_s;
         vy_r       <= vy_nx_s;
         h_acc_r    <= h_acc_nx_s;
         dist_r     <= dist_nx_s;
         height_r   <= height_nx_s;
         done_r     <= done_nx_s;
         busy_r     <= busy_nx_s;
      end
   end

   assign bus.o_jump_done   = done_r;
   assign bus.o_jump_dist   = dist_r;
   assign bus.o_jump_height = height_r;
   assign bus.o_busy        = busy_r;

endmodule

// File: tb/tb_jump_trajectory.sv
// ---------------------------------------------------------------------------
// tb_jump_trajectory
//   Directed bench for jump_trajectory with TICK_DIV=4. Expected values are
//   hand-computed from the parabola h(k) = k*v - k*(k-1)/2 (GRAVITY=1):
//   v=127 peaks at 8128 (height 254) after ticks 127/128 and lands on tick 255.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jump_trajectory;

   logic clk_machine;
   logic rst_machine;
   int   tests_run;
   int   tests_failed;

   jump_trajectory_if jif ();

   jump_trajectory #(
      .TICK_DIV (4),
      .GRAVITY  (1),
      .VX       (1),
      .HSHIFT   (5)
   ) dut (
      .clk_machine (clk_machine),
      .rst_machine (rst_machine),
      .bus         (jif.slave)
   );

   initial clk_machine = 1'b0;
   always #5 clk_machine = ~clk_machine;

   // Count one comparison and report a mismatch
   task automatic check(input string tag, input int got, input int exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance n rising edges, then settle 1ns past the edge
   task automatic edges(input int n);
      repeat (n) @(posedge clk_machine);
      #1;
   endtask

   task automatic check_all(input string tag, input int h, input int d,
                            input int done, input int busy);
      check({tag, ".height"}, int'(jif.o_jump_height), h);
      check({tag, ".dist"},   int'(jif.o_jump_dist),   d);
      check({tag, ".done"},   int'(jif.o_jump_done),   done);
      check({tag, ".busy"},   int'(jif.o_busy),        busy);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_machine  = 1'b1;
      jif.i_jump_en = 1'b0;
      jif.i_v_init  = 11'd0;
      edges(2);
      check_all("reset", 0, 0, 0, 0);
      rst_machine = 1'b0;
      edges(2);

      // Full v=127 flight; velocity change mid-flight must be ignored
      jif.i_v_init  = 11'd127;
      jif.i_jump_en = 1'b1;
      edges(1);
      check_all("start127", 0, 0, 0, 1);
      jif.i_v_init = 11'd5;
      edges(4 * 127);
      check("peak127.height", int'(jif.o_jump_height), 254);
      check("peak127.dist",   int'(jif.o_jump_dist),   127);
      edges(4);
      check("peak128.height", int'(jif.o_jump_height), 254);
      check("peak128.dist",   int'(jif.o_jump_dist),   128);
      edges(1020 - 4 * 128 - 1);
      check("pre_land.done", int'(jif.o_jump_done), 0);
      check("pre_land.busy", int'(jif.o_busy), 1);
      edges(1);
      check_all("land127", 0, 255, 1, 0);

      // Handshake: done holds while enable stays high
      edges(5);
      check_all("hold_done", 0, 255, 1, 0);
      jif.i_jump_en = 1'b0;
      edges(1);
      check_all("drop_en", 0, 255, 0, 0);
      edges(2);
      check_all("idle_hold", 0, 255, 0, 0);

      // Restart clears distance; reset at tick 40
      jif.i_v_init  = 11'd127;
      jif.i_jump_en = 1'b1;
      edges(1);
      check_all("restart", 0, 0, 0, 1);
      edges(4 * 40);
      check("tick40.height", int'(jif.o_jump_height), 134);
      check("tick40.dist",   int'(jif.o_jump_dist),   40);
      rst_machine = 1'b1;
      #1;
      check_all("midreset", 0, 0, 0, 0);
      jif.i_jump_en = 1'b0;
      edges(1);
      check_all("midreset_edge", 0, 0, 0, 0);
      rst_machine = 1'b0;
      edges(1);

      // Oversized initial velocity saturates to 127
      jif.i_v_init  = 11'd300;
      jif.i_jump_en = 1'b1;
      edges(1);
      edges(4 * 127);
      check("v300.peak", int'(jif.o_jump_height), 254);
      edges(1020 - 4 * 127 - 1);
      check("v300.pre_land", int'(jif.o_jump_done), 0);
      edges(1);
      check_all("v300.land", 0, 255, 1, 0);
      jif.i_jump_en = 1'b0;
      edges(1);

      // v=0 lands on tick 1
      jif.i_v_init  = 11'd0;
      jif.i_jump_en = 1'b1;
      edges(1);
      edges(3);
      check_all("v0.pre", 0, 0, 0, 1);
      edges(1);
      check_all("v0.land", 0, 1, 1, 0);
      jif.i_jump_en = 1'b0;
      edges(1);

      // v=1: h_acc 1,1 then lands on tick 3, height stays 0
      jif.i_v_init  = 11'd1;
      jif.i_jump_en = 1'b1;
      edges(1);
      for (int t = 1; t <= 2; t++) begin
         edges(4);
         check("v1.height", int'(jif.o_jump_height), 0);
         check("v1.dist",   int'(jif.o_jump_dist),   t);
         check("v1.done",   int'(jif.o_jump_done),   0);
      end
      edges(4);
      check_all("v1.land", 0, 3, 1, 0);
      jif.i_jump_en = 1'b0;
      edges(1);

      // Abort after tick 50 of v=127
      jif.i_v_init  = 11'd127;
      jif.i_jump_en = 1'b1;
      edges(1);
      edges(4 * 50);
      check_all("tick50", 160, 50, 0, 1);
      jif.i_jump_en = 1'b0;
      edges(1);
      check_all("abort", 0, 50, 0, 0);
      edges(8);
      check_all("abort_hold", 0, 50, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Global time limit so the bench always ends
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish before 200000ns");
      $fatal(1, "timeout");
   end

endmodule
